// File: rtl/hs_pkg.sv
// Shared definitions for the valid/ready handshake blocks: state encoding and
// default widths common to the burst transmitter, the FIFO stage and their benches.
package hs_pkg;

    localparam int HS_DATA_W     = 4;
    localparam int HS_LEN_W      = 4;
    localparam int HS_GAP_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2,
        ST_GAP  = 2'd3
    } hs_state_e;

endpackage

// File: rtl/hs_burst_tx_if.sv
// Control and handshake bundle of the burst transmitter. The master side is the
// transmitter itself; the slave side is whoever issues bursts and consumes words.
interface hs_burst_tx_if #(
    parameter int DATA_W = hs_pkg::HS_DATA_W,
    parameter int LEN_W  = hs_pkg::HS_LEN_W
) ();

    logic              start;
    logic [DATA_W-1:0] base_data;
    logic [LEN_W-1:0]  burst_len;
    logic              r_in;
    logic              v_out;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              done;

    modport master (
        input  start, base_data, burst_len, r_in,
        output v_out, data_out, busy, done
    );

    modport slave (
        output start, base_data, burst_len, r_in,
        input  v_out, data_out, busy, done
    );

endinterface

// File: rtl/hs_gap_timer.sv
// Loadable down-counter with a zero flag; paces the idle gap between beats
// when the transmitter is built with HS_TX_GAP_EN.
module hs_gap_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over counting; the counter parks at zero until reloaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hs_burst_tx.sv
// Burst source for the valid/ready handshake: on start it sends burst_len words
// counting up from base_data. Define HS_TX_GAP_EN to insert GAP_CYCLES idle cycles between beats.
module hs_burst_tx
    import hs_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W,
    parameter int LEN_W  = HS_LEN_W
`ifdef HS_TX_GAP_EN
    , parameter int GAP_CYCLES = HS_GAP_CYCLES
`endif
) (
    input logic           clk,
    input logic           reset,
    hs_burst_tx_if.master bus
);

    hs_state_e         state;
    logic              v_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;
    logic              done_q;
    logic [LEN_W-1:0]  beats_left;

    logic xfer;
    logic last_beat;

    assign xfer      = (state == ST_SEND) && v_q && bus.r_in;
    assign last_beat = (beats_left == LEN_W'(1));

`ifdef HS_TX_GAP_EN
    logic gap_zero;

    // Loaded at each non-last transfer with one less than the gap length,
    // because the cycle that sees zero is itself the final gap cycle.
    hs_gap_timer #(.W(4)) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (xfer && !last_beat),
        .load_val (4'(GAP_CYCLES - 1)),
        .zero     (gap_zero)
    );
`endif

    // All outputs are registered, so valid never follows ready combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            v_q        <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            beats_left <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (bus.burst_len != '0) begin
                            data_q     <= bus.base_data;
                            beats_left <= bus.burst_len;
                            v_q        <= 1'b1;
                            busy_q     <= 1'b1;
                            state      <= ST_SEND;
                        end else begin
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end

                ST_SEND: begin
                    if (xfer) begin
                        beats_left <= beats_left - LEN_W'(1);
                        if (last_beat) begin
                            v_q    <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            data_q <= data_q + DATA_W'(1);
`ifdef HS_TX_GAP_EN
                            v_q    <= 1'b0;
                            state  <= ST_GAP;
`endif
                        end
                    end
                end

                ST_DONE: begin
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end

`ifdef HS_TX_GAP_EN
                ST_GAP: begin
                    if (gap_zero) begin
                        v_q   <= 1'b1;
                        state <= ST_SEND;
                    end
                end
`endif

                default: begin
                    v_q    <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.v_out    = v_q;
    assign bus.data_out = data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
